// File: rtl/button_event_pkg.sv
// Shared event codes, FSM state encoding and helpers for the button event decoder.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (REPEAT events while long-held).
package button_event_pkg;

   localparam int unsigned EvtCodeW = 3;

   typedef enum logic [EvtCodeW-1:0] {
      EvtNone   = 3'd0,
      EvtShort  = 3'd1,
      EvtLong   = 3'd2,
      EvtDouble = 3'd3,
      EvtRepeat = 3'd4
   } evt_code_e;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPress1   = 3'd1,
      StWait2    = 3'd2,
      StPress2   = 3'd3,
      StLongHeld = 3'd4
   } state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/event_slot.sv
// One-entry valid/ready event register with a sticky overflow flag.
// Used by button_event_decoder (macro BUTTON_AUTO_REPEAT_EN does not affect this file).
module event_slot
   import button_event_pkg::*;
(
   input  logic      clk_tick,
   input  logic      rst,
   input  logic      push,
   input  evt_code_e push_code,
   input  logic      evt_ready,
   output logic      evt_valid,
   output evt_code_e evt_code,
   output logic      evt_ovf
);

   always_ff @(posedge clk_tick or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_code  <= EvtNone;
         evt_ovf   <= 1'b0;
      end else if (push) begin
         // A push may replace an entry that is being accepted on this same edge.
         if (!evt_valid || evt_ready) begin
            evt_valid <= 1'b1;
            evt_code  <= push_code;
         end else begin
            evt_ovf <= 1'b1;
         end
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
         evt_code  <= EvtNone;
      end
   end

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into SHORT/LONG/DOUBLE (and REPEAT) gesture events.
// Macro BUTTON_AUTO_REPEAT_EN enables REPEAT events every REPEAT_TICKS while long-held.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int unsigned LONG_TICKS   = 100,
   parameter int unsigned DCLICK_TICKS = 30,
   parameter int unsigned REPEAT_TICKS = 20
) (
   input  logic                clk_tick,
   input  logic                rst,
   input  logic                sigI,
   input  logic                evt_ready,
   output logic                evt_valid,
   output logic [EvtCodeW-1:0] evt_code,
   output logic                evt_ovf
);

   localparam int unsigned CntW = $clog2(max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS)) + 1;
   localparam logic [CntW-1:0] CntSat     = '1;
   localparam logic [CntW-1:0] LongLast   = CntW'(LONG_TICKS - 1);
   localparam logic [CntW-1:0] DclickLast = CntW'(DCLICK_TICKS);
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_TICKS - 1);
`endif

   state_e          state;
   logic [CntW-1:0] cnt;
   logic            push;
   evt_code_e       push_code;
   evt_code_e       slot_code;

   function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] c);
      return (c == CntSat) ? c : c + CntW'(1);
   endfunction

   // push/push_code are registered, so the slot loads one edge after the trigger.
   always_ff @(posedge clk_tick or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         cnt       <= '0;
         push      <= 1'b0;
         push_code <= EvtNone;
      end else begin
         push      <= 1'b0;
         push_code <= EvtNone;
         unique case (state)
            StIdle: begin
               if (sigI) begin
                  state <= StPress1;
                  cnt   <= CntW'(1);
               end
            end
            StPress1: begin
               if (!sigI) begin
                  state <= StWait2;
                  cnt   <= CntW'(1);
               end else if (cnt == LongLast) begin
                  state     <= StLongHeld;
                  cnt       <= '0;
                  push      <= 1'b1;
                  push_code <= EvtLong;
               end else begin
                  cnt <= cnt_inc(cnt);
               end
            end
            StWait2: begin
               if (sigI) begin
                  state <= StPress2;
               end else if (cnt == DclickLast) begin
                  state     <= StIdle;
                  push      <= 1'b1;
                  push_code <= EvtShort;
               end else begin
                  cnt <= cnt_inc(cnt);
               end
            end
            StPress2: begin
               if (!sigI) begin
                  state     <= StIdle;
                  push      <= 1'b1;
                  push_code <= EvtDouble;
               end
            end
            StLongHeld: begin
               if (!sigI) begin
                  state <= StIdle;
`ifdef BUTTON_AUTO_REPEAT_EN
               end else if (cnt == RepeatLast) begin
                  cnt       <= '0;
                  push      <= 1'b1;
                  push_code <= EvtRepeat;
               end else begin
                  cnt <= cnt_inc(cnt);
`endif
               end
            end
            default: begin
               state <= StIdle;
               cnt   <= '0;
            end
         endcase
      end
   end

   event_slot u_slot (
      .clk_tick  (clk_tick),
      .rst       (rst),
      .push      (push),
      .push_code (push_code),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (slot_code),
      .evt_ovf   (evt_ovf)
   );

   assign evt_code = slot_code;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a run-length gesture model and slot model.
// Honours BUTTON_AUTO_REPEAT_EN in the model when the RTL is built with it.
module tb_button_event_decoder;
   import button_event_pkg::*;

   localparam int unsigned L = 8;
   localparam int unsigned D = 4;
   localparam int unsigned R = 3;
   localparam int MAXN = 64;
   localparam int EVN  = MAXN + 16;

   logic       clk_tick = 1'b0;
   logic       rst = 1'b0;
   logic       sigI = 1'b0;
   logic       evt_ready = 1'b1;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic       evt_ovf;

   button_event_decoder #(
      .LONG_TICKS   (L),
      .DCLICK_TICKS (D),
      .REPEAT_TICKS (R)
   ) dut (
      .clk_tick  (clk_tick),
      .rst       (rst),
      .sigI      (sigI),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ovf   (evt_ovf)
   );

   always #5 clk_tick = ~clk_tick;

   bit stim [MAXN];
   bit rdy  [MAXN];
   int ev   [EVN];
   bit ex_v [MAXN];
   int ex_c [MAXN];
   bit ex_o [MAXN];
   bit mv, mo;
   int mc;
   int n_checks = 0;
   int n_pass = 0;
   int cur = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, got, want);
   endtask

   // Length of the run of 'val' starting at 'from'; a zero run reaching the end is endless.
   function automatic int run_len(input int from, input int n, input bit val);
      int c;
      c = 0;
      while (from + c < n && stim[from + c] == val) c++;
      if (!val && from + c >= n) c = 1000;
      return c;
   endfunction

   // Gesture events by edge index at which the trigger is sampled, from press/gap lengths.
   function automatic void model_events(input int n);
      int i, p, h, r, g, q, h2;
      for (int k = 0; k < EVN; k++) ev[k] = 0;
      i = 0;
      while (i < n) begin
         if (!stim[i]) begin
            i++;
         end else begin
            p = i;
            h = run_len(p, n, 1'b1);
            if (h >= int'(L)) begin
               ev[p + L - 1] = int'(EvtLong);
`ifdef BUTTON_AUTO_REPEAT_EN
               for (int j = 1; p + int'(L) - 1 + int'(R) * j < p + h; j++)
                  ev[p + L - 1 + R * j] = int'(EvtRepeat);
`endif
               i = p + h + 1;
            end else begin
               r = p + h;
               g = run_len(r, n, 1'b0);
               if (g > int'(D)) begin
                  ev[r + D] = int'(EvtShort);
                  i = r + D + 1;
               end else begin
                  q  = r + g;
                  h2 = run_len(q, n, 1'b1);
                  ev[q + h2] = int'(EvtDouble);
                  i = q + h2 + 1;
               end
            end
         end
      end
   endfunction

   // Expected slot outputs after each edge; an event decided at edge k-1 arrives at edge k.
   function automatic void model_slot(input int n);
      int push;
      for (int k = 0; k < n; k++) begin
         push = (k > 0) ? ev[k - 1] : 0;
         if (push != 0) begin
            if (!mv || rdy[k]) begin
               mv = 1'b1;
               mc = push;
            end else begin
               mo = 1'b1;
            end
         end else if (mv && rdy[k]) begin
            mv = 1'b0;
            mc = 0;
         end
         ex_v[k] = mv;
         ex_c[k] = mc;
         ex_o[k] = mo;
      end
   endfunction

   function automatic int n_events();
      int c;
      c = 0;
      for (int k = 0; k < EVN; k++) if (ev[k] != 0) c++;
      return c;
   endfunction

   always @(posedge clk_tick) begin
      #1;
      if (chk_en) begin
         check($sformatf("valid@%0d", cur), int'(evt_valid), int'(ex_v[cur]));
         check($sformatf("code@%0d", cur), int'(evt_code), ex_c[cur]);
         check($sformatf("ovf@%0d", cur), int'(evt_ovf), int'(ex_o[cur]));
      end
   end

   // Entered at a falling edge (or time 0); returns at a falling edge.
   task automatic run(input string s, input string rp, input bit do_reset);
      int n;
      n = s.len();
      for (int i = 0; i < MAXN; i++) begin
         stim[i] = 1'b0;
         rdy[i]  = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         stim[i] = (s.getc(i) == "1");
         if (rp.len() > i) rdy[i] = (rp.getc(i) == "1");
      end
      if (do_reset) begin
         #2;
         rst = 1'b1;
         sigI = 1'b0;
         evt_ready = 1'b1;
         #1;
         check("rst_valid", int'(evt_valid), 0);
         check("rst_code", int'(evt_code), 0);
         check("rst_ovf", int'(evt_ovf), 0);
         mv = 1'b0;
         mo = 1'b0;
         mc = 0;
         #1 rst = 1'b0;
         @(negedge clk_tick);
      end
      model_events(n);
      model_slot(n);
      for (int k = 0; k < n; k++) begin
         sigI = stim[k];
         evt_ready = rdy[k];
         cur = k;
         chk_en = 1'b1;
         @(negedge clk_tick);
      end
      chk_en = 1'b0;
   endtask

   initial begin
      // Short press
      run("0111000000000000", "", 1'b1);
      check("m_s1_count", n_events(), 1);
      check("m_s1_short", ev[8], int'(EvtShort));
      // Long press, 12 ticks
      run("01111111111110000000000", "", 1'b1);
      check("m_s2_long", ev[8], int'(EvtLong));
`ifdef BUTTON_AUTO_REPEAT_EN
      check("m_s2_count", n_events(), 2);
      check("m_s2_repeat", ev[11], int'(EvtRepeat));
`else
      check("m_s2_count", n_events(), 1);
`endif
      // Double click
      run("01100110000000000", "", 1'b1);
      check("m_s3_count", n_events(), 1);
      check("m_s3_double", ev[7], int'(EvtDouble));
      // Gap one past the limit: two separate shorts
      run("0110000011000000000000", "", 1'b1);
      check("m_s4_count", n_events(), 2);
      check("m_s4_first", ev[7], int'(EvtShort));
      check("m_s4_second", ev[14], int'(EvtShort));
      // Release on the LONG compare edge
      run("01111111000000000000", "", 1'b1);
      check("m_rel_on_long", ev[12], int'(EvtShort));
      // Press on the DCLICK edge
      run("01100001100000000000", "", 1'b1);
      check("m_press_on_dclick", ev[9], int'(EvtDouble));
      // Back-pressure: second short dropped, ready drains only the first
      run("011000000000110000000000000000", "000000000000000000000000111111", 1'b1);
      check("m_bp_first", ev[7], int'(EvtShort));
      check("m_bp_second", ev[18], int'(EvtShort));
      check("m_bp_ovf", int'(ex_o[29]), 1);
      // Start of a long press, then reset mid-gesture
      run("01111", "", 1'b0);
      run("00000000000000", "", 1'b1);
      check("m_rst_count", n_events(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
